// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: shared mode encoding, counter width and zero-as-one helper for step_clock_ctrl
package step_ctrl_pkg;
  typedef enum logic [1:0] {MODE_IDLE = 2'd0, MODE_BURST = 2'd1, MODE_RUN = 2'd2} mode_e;
  localparam int EN_COUNT_W = 32;
  function automatic logic [31:0] max1(input logic [31:0] v);
    return (v == '0) ? 32'd1 : v;
  endfunction
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-FF synchroniser, consecutive-sample debounce and one-cycle press on the debounced rise
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d;
  // any sample agreeing with the current level restarts the count
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = (sync_q[1] == level_q || cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    level_d = (sync_q[1] != level_q && cnt_q == CNT_MAX) ? ~level_q : level_q;
    press_d = level_d & ~level_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: debounced IDLE/BURST/RUN clock-enable controller; breakpoint stop under STEP_CTRL_BREAKPOINT_EN
module step_clock_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_W           = 16,
  parameter int BURST_W         = 8,
  parameter int PC_W            = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  step_btn,
  input  logic                  run_btn,
  input  logic [DIV_W-1:0]      div_ratio,
  input  logic [BURST_W-1:0]    burst_len,
  input  logic                  halt_req,
  output logic                  cpu_en,
  output logic                  busy,
  output logic [1:0]            mode,
  output logic                  done,
  output logic [EN_COUNT_W-1:0] en_count
`ifdef STEP_CTRL_BREAKPOINT_EN
  ,
  input  logic                  bp_valid,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic [PC_W-1:0]       pc_in,
  output logic                  bp_hit
`endif
);
  logic step_press, run_press, step_level_unused, run_level_unused;
  mode_e mode_q, mode_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, eff_div_q, eff_div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [EN_COUNT_W-1:0] en_count_q, en_count_d;
  logic done_q, done_d, busy_w, en_raw, issue, bp_stop, stop;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .reset_n(reset_n), .btn_raw(step_btn), .level(step_level_unused), .press(step_press)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .reset_n(reset_n), .btn_raw(run_btn), .level(run_level_unused), .press(run_press)
  );

`ifdef STEP_CTRL_BREAKPOINT_EN
  logic bp_hit_q;
  assign bp_stop = (mode_q == MODE_RUN) && en_raw && bp_valid && (pc_in == bp_addr);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bp_hit_q <= 1'b0;
    else          bp_hit_q <= bp_stop;
  end
  assign bp_hit = bp_hit_q;
`else
  localparam int pc_w_unused = PC_W;
  assign bp_stop = 1'b0;
`endif

  // ratios are re-latched every idle cycle so the value seen on the entry edge sticks
  always_comb begin
    busy_w     = mode_q != MODE_IDLE;
    en_raw     = busy_w && (div_cnt_q == eff_div_q - DIV_W'(1));
    issue      = en_raw && !bp_stop;
    div_cnt_d  = (!busy_w || en_raw) ? '0 : div_cnt_q + DIV_W'(1);
    eff_div_d  = busy_w ? eff_div_q : DIV_W'(max1(32'(div_ratio)));
    rem_d      = !busy_w ? BURST_W'(max1(32'(burst_len))) :
                 (mode_q == MODE_BURST && issue) ? rem_q - BURST_W'(1) : rem_q;
    en_count_d = en_count_q + EN_COUNT_W'(issue);
    stop       = (mode_q == MODE_BURST && ((issue && rem_q == BURST_W'(1)) || halt_req)) ||
                 (mode_q == MODE_RUN && (run_press || halt_req || bp_stop));
    mode_d     = stop ? MODE_IDLE :
                 (mode_q != MODE_IDLE) ? mode_q :
                 run_press ? MODE_RUN : step_press ? MODE_BURST : MODE_IDLE;
    done_d     = stop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_IDLE;
      div_cnt_q  <= '0;
      eff_div_q  <= '0;
      rem_q      <= '0;
      en_count_q <= '0;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      div_cnt_q  <= div_cnt_d;
      eff_div_q  <= eff_div_d;
      rem_q      <= rem_d;
      en_count_q <= en_count_d;
      done_q     <= done_d;
    end
  end

  assign cpu_en   = issue;
  assign busy     = busy_w;
  assign mode     = mode_q;
  assign done     = done_q;
  assign en_count = en_count_q;
endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb_step_clock_ctrl: directed and random stimulus against a cycle-history reference model of step_clock_ctrl
module tb_step_clock_ctrl;
  localparam int D = 4;
  localparam int N = 4096;
  logic clk = 1'b0, reset_n = 1'b0, step_btn = 1'b0, run_btn = 1'b0, halt_req = 1'b0;
  logic [15:0] div_ratio = '0;
  logic [7:0] burst_len = '0;
  logic cpu_en, busy, done;
  logic [1:0] mode;
  logic [31:0] en_count;
`ifdef STEP_CTRL_BREAKPOINT_EN
  logic bp_valid = 1'b0, bp_hit;
  logic [63:0] bp_addr = 64'h10, pc_in = '0;
`endif

  step_clock_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .step_btn(step_btn), .run_btn(run_btn),
    .div_ratio(div_ratio), .burst_len(burst_len), .halt_req(halt_req),
    .cpu_en(cpu_en), .busy(busy), .mode(mode), .done(done), .en_count(en_count)
`ifdef STEP_CTRL_BREAKPOINT_EN
    , .bp_valid(bp_valid), .bp_addr(bp_addr), .pc_in(pc_in), .bp_hit(bp_hit)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: raw button history per edge, abstract mode and enable schedule
  bit rawb [2][N];
  int cyc, m_mode, m_entry, m_div, m_rem;
  bit m_lvl [2];
  bit m_press [2];
  bit m_done, m_bphit;
  logic [31:0] m_cnt;
  bit nx_step, nx_run, nx_halt, nx_bpv, halt_arm;
  int nx_div, nx_burst;
  logic [63:0] nx_pc;
  logic [31:0] halt_cnt;
  int obs_en, obs_done, obs_bp;

  function automatic bit smp(input int b, input int k);
    return (k <= 0) ? 1'b0 : rawb[b][k];
  endfunction

  function automatic bit exp_en();
    return (m_mode != 0) && (((cyc - m_entry) % m_div) == m_div - 1);
  endfunction

  function automatic bit bpm();
`ifdef STEP_CTRL_BREAKPOINT_EN
    return (m_mode == 2) && exp_en() && nx_bpv && (nx_pc == 64'h10);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_init();
    cyc = 0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) rawb[b][k] = 1'b0;
      m_lvl[b] = 1'b0;
      m_press[b] = 1'b0;
    end
    m_mode = 0; m_entry = 0; m_div = 1; m_rem = 0;
    m_cnt = '0; m_done = 1'b0; m_bphit = 1'b0;
  endtask

  task automatic tick();
    bit nh, en, bp, stop, flip;
    @(negedge clk);
    if (cyc >= N - 2) begin
      $display("FAIL budget: got=%0d exp<%0d", cyc, N - 2);
      $fatal(1);
    end
    nh = nx_halt | (halt_arm && exp_en() && (m_cnt == halt_cnt - 1));
    step_btn = nx_step; run_btn = nx_run; halt_req = nh;
    div_ratio = 16'(nx_div); burst_len = 8'(nx_burst);
`ifdef STEP_CTRL_BREAKPOINT_EN
    bp_valid = nx_bpv; pc_in = nx_pc;
`endif
    rawb[0][cyc+1] = nx_step;
    rawb[1][cyc+1] = nx_run;
    #1;
    bp = bpm();
    en = exp_en() && !bp;
    check("cpu_en", 64'(cpu_en), 64'(en));
    check("mode", 64'(mode), 64'(m_mode));
    check("busy", 64'(busy), 64'(m_mode != 0));
    check("done", 64'(done), 64'(m_done));
    check("en_count", 64'(en_count), 64'(m_cnt));
`ifdef STEP_CTRL_BREAKPOINT_EN
    check("bp_hit", 64'(bp_hit), 64'(m_bphit));
    obs_bp += int'(bp_hit);
`endif
    obs_en += int'(cpu_en);
    obs_done += int'(done);
    stop = 1'b0;
    if (m_mode == 1) begin
      if (en) m_rem--;
      stop = (en && m_rem == 0) || nh;
    end else if (m_mode == 2) stop = m_press[1] || nh || bp;
    m_done = stop;
    m_bphit = bp;
    m_cnt += 32'(en);
    if (stop) m_mode = 0;
    else if (m_mode == 0 && (m_press[0] || m_press[1])) begin
      m_mode = m_press[1] ? 2 : 1;
      m_entry = cyc + 1;
      m_div = (nx_div == 0) ? 1 : nx_div;
      m_rem = (nx_burst == 0) ? 1 : nx_burst;
    end
    for (int b = 0; b < 2; b++) begin
      flip = 1'b1;
      for (int j = 0; j < D; j++) if (smp(b, cyc - 1 - j) == m_lvl[b]) flip = 1'b0;
      m_press[b] = flip && !m_lvl[b];
      if (flip) m_lvl[b] = !m_lvl[b];
    end
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    step_btn = nx_step;
    run_btn = nx_run;
    #1;
    check({tag, "_cpu_en"}, 64'(cpu_en), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_mode"}, 64'(mode), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_en_count"}, 64'(en_count), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_init();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got=%0t exp=finish", $time);
    $fatal(1);
  end

  initial begin
    nx_step = 0; nx_run = 0; nx_halt = 0; nx_bpv = 0; halt_arm = 0;
    nx_div = 0; nx_burst = 0; nx_pc = '0; halt_cnt = '0;
    obs_en = 0; obs_done = 0; obs_bp = 0;
    model_init();
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_cpu_en", 64'(cpu_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mode", 64'(mode), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_en_count", 64'(en_count), 64'd0);
    reset_n = 1'b1;

    nx_step = 1; repeat (3) tick();
    nx_step = 0; repeat (12) tick();
    check("t1_en_count", 64'(en_count), 64'd0);
    check("t1_mode", 64'(mode), 64'd0);

    nx_div = 3; nx_burst = 2; obs_en = 0; obs_done = 0;
    nx_step = 1; repeat (10) tick();
    nx_step = 0; repeat (20) tick();
    check("t2_enables", 64'(obs_en), 64'd2);
    check("t2_done", 64'(obs_done), 64'd1);
    check("t2_en_count", 64'(en_count), 64'd2);

    nx_div = 0; nx_burst = 0; obs_en = 0;
    nx_step = 1; repeat (8) tick();
    nx_step = 0; repeat (12) tick();
    check("t3_enables", 64'(obs_en), 64'd1);
    check("t3_en_count", 64'(en_count), 64'd3);

    nx_div = 1; halt_arm = 1; halt_cnt = 32'd8; obs_done = 0;
    nx_run = 1; repeat (7) tick();
    nx_run = 0; repeat (20) tick();
    halt_arm = 0;
    check("t4_en_count", 64'(en_count), 64'd8);
    check("t4_done", 64'(obs_done), 64'd1);

    nx_div = 1;
    nx_run = 1; repeat (7) tick();
    nx_run = 0; repeat (5) tick();
    check("t5_pre_busy", 64'(busy), 64'd1);
    do_reset("t5");
    repeat (20) tick();
    check("t5_en_count", 64'(en_count), 64'd0);
    check("t5_mode", 64'(mode), 64'd0);

`ifdef STEP_CTRL_BREAKPOINT_EN
    nx_bpv = 1; nx_pc = 64'h10; nx_div = 1; nx_burst = 1; obs_bp = 0; obs_en = 0;
    nx_run = 1; repeat (7) tick();
    nx_run = 0; repeat (8) tick();
    check("t6_bp_hit", 64'(obs_bp), 64'd1);
    check("t6_en_count", 64'(en_count), 64'd0);
    obs_en = 0;
    nx_step = 1; repeat (7) tick();
    nx_step = 0; repeat (8) tick();
    check("t6_step_en", 64'(obs_en), 64'd1);
    check("t6_step_count", 64'(en_count), 64'd1);
    nx_bpv = 0;
`endif

    nx_step = 1; nx_div = 1; nx_burst = 1;
    do_reset("t7");
    obs_en = 0;
    repeat (15) tick();
    nx_step = 0; repeat (8) tick();
    check("t7_held_en", 64'(obs_en), 64'd1);
    check("t7_en_count", 64'(en_count), 64'd1);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) nx_step = !nx_step;
      if ($urandom_range(10) == 0) nx_run = !nx_run;
      nx_halt = ($urandom_range(39) == 0);
      if (i % 64 == 0) begin
        nx_div = int'($urandom_range(3));
        nx_burst = int'($urandom_range(3));
      end
`ifdef STEP_CTRL_BREAKPOINT_EN
      if (i % 16 == 0) nx_bpv = 1'($urandom_range(1));
      nx_pc = ($urandom_range(3) == 0) ? 64'h10 : 64'h14;
`endif
      tick();
    end
    nx_halt = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/step_clock_ctrl.md
Name: step_clock_ctrl

Overview:
Parametrised, debounced execution-control unit for the RISC-V core. It replaces the fixed three-state button pulse generator. It produces a single-cycle clock enable (cpu_en) on the system clock, so the core runs on clk with no derived clock. Modes are IDLE, BURST (N enables per step press) and RUN (free-running at a programmable divide ratio).

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a button level (synthesis builds use e.g. 500000).
DIV_W, 16, width of div_ratio.
BURST_W, 8, width of burst_len.
PC_W, 64, width of pc_in/bp_addr (only used with the optional feature).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
step_btn  in  1  raw asynchronous step button
run_btn  in  1  raw asynchronous run/stop toggle button
div_ratio  in  DIV_W  enable period in clocks; 0 treated as 1
burst_len  in  BURST_W  enables per step press; 0 treated as 1
halt_req  in  1  synchronous stop request from the core
cpu_en  out  1  single-cycle core enable
busy  out  1  high when mode != IDLE
mode  out  2  0=IDLE, 1=BURST, 2=RUN
done  out  1  one-cycle pulse on return to IDLE
en_count  out  32  total enables issued; wraps at 2^32

Behaviour:
- Reset (reset_n low, asynchronous): mode IDLE, cpu_en 0, busy 0, done 0, en_count 0, all sync/debounce/divider/burst counters 0, debounced levels 0. Takes effect mid-operation immediately.
- Button conditioning:
  - 2-FF synchroniser feeds a debounce counter.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - A press is a one-cycle pulse on the debounced rising edge. Press latency from a clean input edge is 2 + DEBOUNCE_CYCLES clocks.
  - A button held across reset release generates one press.
- eff_div = max(div_ratio, 1) and eff_burst = max(burst_len, 1). Both are latched on entry to BURST/RUN. Input changes mid-operation are ignored until the next entry.
- Divider: div_cnt is cleared to 0 on entry. It counts 0..eff_div-1 while busy and wraps.
- cpu_en = busy && (div_cnt == eff_div-1). It is a Moore output decoded from registers, except for the breakpoint suppression below. With eff_div=1, cpu_en is high in every busy cycle, starting with the first.
- IDLE transitions:
  - run press → RUN.
  - Else step press → BURST, with remaining = eff_burst.
  - Simultaneous step and run press: run wins.
  - halt_req is ignored.
- BURST transitions:
  - Each cpu_en decrements remaining.
  - cpu_en with remaining == 1 → IDLE next cycle, done pulses that cycle.
  - halt_req → IDLE next cycle, with done. A cpu_en in the same cycle is still issued and counted.
  - Step and run presses are ignored.
- RUN transitions:
  - run press or halt_req → IDLE next cycle, with done. A cpu_en coinciding with either is still issued.
  - Step presses are ignored.
- en_count increments on every issued cpu_en.

Optional Feature:
Macro STEP_CTRL_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_valid (in, 1), bp_addr (in, PC_W), pc_in (in, PC_W; PC of the next instruction to execute) and bp_hit (out, 1).
  - In RUN, if bp_valid && pc_in == bp_addr in a cycle where cpu_en would assert, cpu_en is suppressed and not counted. In that case mode → IDLE next cycle, and bp_hit and done pulse one cycle.
  - Breakpoints are not checked in BURST, so stepping off a breakpoint works.
  - bp_hit resets to 0.
- Undefined: these ports and the logic are absent, and behaviour is exactly as above.

Decomposition:
- Package step_ctrl_pkg contains:
  - mode_e enum {MODE_IDLE=2'd0, MODE_BURST=2'd1, MODE_RUN=2'd2};
  - EN_COUNT_W=32;
  - a max1 helper function for the zero-as-one rule.
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES; ports clk, reset_n, btn_raw, level, press). It is instantiated once per button.
- The FSM, divider and counters live in step_clock_ctrl.

Test Plan:
1. DEBOUNCE_CYCLES=4; step_btn high for 3 clocks → no press, cpu_en never asserts, en_count=0, mode stays 0.
2. div_ratio=3, burst_len=2, step held for 10 clocks → mode=1. cpu_en asserts exactly twice, 3 clocks apart, the first 3 clocks after entry. done pulses once, en_count=2, then mode=0.
3. div_ratio=0, burst_len=0, step press → exactly one cpu_en, in the first BURST cycle; en_count=1.
4. div_ratio=1, run press → cpu_en every cycle. halt_req asserted in the cycle of the 5th enable → en_count=5, mode=0 next cycle, done=1.
5. In RUN, reset_n pulled low between clock edges → cpu_en, busy and en_count go to 0 immediately and mode=0. After release with no buttons pressed, no enables occur.
6. (STEP_CTRL_BREAKPOINT_EN) bp_valid=1, bp_addr=0x10, RUN with pc_in=0x10 → cpu_en suppressed, bp_hit=1 for one cycle, mode=0, en_count unchanged. A following step press issues one enable despite pc_in=0x10.
